quad_decoder: RTL and testbench

- Quadrature encoder front end. Converts asynchronous A/B encoder lines into a one-cycle count-enable pulse `en` and a direction level `mode`.
- Sits directly upstream of upDownCounterNbit; `en`/`mode` connect 1:1 to the counter's `en`/`mode` inputs.
- Input sync, glitch filtering, resolution select (x1/x2/x4) and illegal-transition detection are all handled here, so the counter sees only clean, legal steps.

---
 rtl/quad_decoder_pkg.sv | 41 ++++
 rtl/quad_decoder_sync_filter.sv | 53 +++++
 rtl/quad_decoder.sv | 111 +++++++++++
 tb/tb_quad_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_decoder_pkg.sv
// Shared constants, FSM states and Gray-step classification for the quadrature decoder.
package quad_pkg;

    localparam int RES_X1   = 1;
    localparam int RES_X2   = 2;
    localparam int RES_X4   = 4;
    localparam int FILT_MAX = 255;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    // Forward Gray order on {A,B}: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic step_t classify_step(input logic [1:0] ab_ref, input logic [1:0] ab_new);
        if (ab_new == ab_ref)
            return STEP_NONE;
        if ((ab_new ^ ab_ref) == 2'b11)
            return STEP_ILLEGAL;
        if (ab_new == fwd_next(ab_ref))
            return STEP_FWD;
        return STEP_REV;
    endfunction

endpackage

// File: rtl/quad_decoder_sync_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only follows
// the input once it has held the same value for FILT_LEN consecutive cycles.
module sync_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic vld
);

    localparam logic [7:0] FILT_CNT = 8'(FILT_LEN);

    logic       sync_p0;
    logic       sync_p1;
    logic       last_p2;
    logic [7:0] cnt_p2;
    logic [7:0] cnt_nxt;
    logic       hit;

    // A changed sample restarts the run at 1; the run saturates at FILT_CNT so
    // acceptance fires once per stable run.
    always_comb begin
        cnt_nxt = cnt_p2;
        if (sync_p1 != last_p2)
            cnt_nxt = 8'd1;
        else if (cnt_p2 != FILT_CNT)
            cnt_nxt = cnt_p2 + 8'd1;
        hit = (cnt_nxt == FILT_CNT) && ((sync_p1 != last_p2) || (cnt_p2 != FILT_CNT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            last_p2 <= 1'b0;
            cnt_p2  <= 8'd0;
            dout    <= 1'b0;
            vld     <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            last_p2 <= sync_p1;
            cnt_p2  <= cnt_nxt;
            if (hit) begin
                dout <= sync_p1;
                vld  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: filtered A/B in, one-cycle count enable plus
// direction out, with a sticky flag for illegal double-bit transitions.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int RES      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_in,
    input  logic b_in,
    input  logic err_clr,
    output logic en,
    output logic mode,
    output logic err
);

    generate
        if (RES != RES_X1 && RES != RES_X2 && RES != RES_X4) begin : g_bad_res
            $error("quad_decoder: RES must be 1, 2 or 4");
        end
        if (FILT_LEN < 1 || FILT_LEN > FILT_MAX) begin : g_bad_filt
            $error("quad_decoder: FILT_LEN must be in 1..255");
        end
    endgenerate

    logic       a_filt;
    logic       b_filt;
    logic       a_vld;
    logic       b_vld;
    logic [1:0] ab_filt;
    logic [1:0] ab_ref;
    state_t     state;
    step_t      step;

    sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk  (clk),
        .rst  (rst),
        .din  (a_in),
        .dout (a_filt),
        .vld  (a_vld)
    );

    sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk  (clk),
        .rst  (rst),
        .din  (b_in),
        .dout (b_filt),
        .vld  (b_vld)
    );

    // Resolution gating: x4 counts every step, x2 only A edges, x1 only the 01<->00 step.
    function automatic logic step_counts(input logic [1:0] prev, input logic [1:0] nxt);
        if (RES == RES_X4)
            return 1'b1;
        if (RES == RES_X2)
            return prev[1] != nxt[1];
        return ((prev == 2'b01) && (nxt == 2'b00)) || ((prev == 2'b00) && (nxt == 2'b01));
    endfunction

    assign ab_filt = {a_filt, b_filt};

    always_comb begin
        step = classify_step(ab_ref, ab_filt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_INIT;
            ab_ref <= 2'b00;
            en     <= 1'b0;
            mode   <= 1'b1;
            err    <= 1'b0;
        end else begin
            en <= 1'b0;
            if (err_clr)
                err <= 1'b0;
            case (state)
                ST_INIT: begin
                    // Reference is only trusted once both channels have settled.
                    if (a_vld && b_vld) begin
                        ab_ref <= ab_filt;
                        state  <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    case (step)
                        STEP_FWD: begin
                            ab_ref <= ab_filt;
                            mode   <= 1'b1;
                            en     <= step_counts(ab_ref, ab_filt);
                        end
                        STEP_REV: begin
                            ab_ref <= ab_filt;
                            mode   <= 1'b0;
                            en     <= step_counts(ab_ref, ab_filt);
                        end
                        STEP_ILLEGAL: begin
                            ab_ref <= ab_filt;
                            err    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench: three decoders (RES 4/2/1) share one A/B stimulus stream;
// expected count pulses are queued at drive time and matched against en.
module tb_quad_decoder;

    localparam int FL = 4;

    typedef struct {
        int cyc;
        int mode;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_in;
    logic       b_in;
    logic       err_clr;
    logic [2:0] en_v;
    logic [2:0] mode_v;
    logic [2:0] err_v;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    exp_t       sb_q [3][$];
    exp_t       mon_e;
    logic [1:0] m_ref;
    int         m_mode;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        quad_decoder #(.FILT_LEN(FL), .RES((g == 0) ? 4 : ((g == 1) ? 2 : 1))) u_dut (
            .clk     (clk),
            .rst     (rst),
            .a_in    (a_in),
            .b_in    (b_in),
            .err_clr (err_clr),
            .en      (en_v[g]),
            .mode    (mode_v[g]),
            .err     (err_v[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int res_of(input int r);
        return (r == 0) ? 4 : ((r == 1) ? 2 : 1);
    endfunction

    function automatic int gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit counts(input int res, input logic [1:0] p, input logic [1:0] n);
        if (res == 4)
            return 1'b1;
        if (res == 2)
            return p[1] != n[1];
        return ((p == 2'b01) && (n == 2'b00)) || ((p == 2'b00) && (n == 2'b01));
    endfunction

    // Drive a new AB level, predict its outcome, then hold for n_hold more edges.
    task automatic step_to(input logic a, input logic b, input int n_hold);
        logic [1:0] nab;
        int         d;
        exp_t       e;
        @(posedge clk);
        #1;
        a_in = a;
        b_in = b;
        nab  = {a, b};
        d    = (gray_pos(nab) - gray_pos(m_ref) + 4) % 4;
        if (d == 1 || d == 3) begin
            m_mode = (d == 1) ? 1 : 0;
            for (int r = 0; r < 3; r++) begin
                if (counts(res_of(r), m_ref, nab)) begin
                    e.cyc  = cyc + FL + 3;
                    e.mode = m_mode;
                    sb_q[r].push_back(e);
                end
            end
        end
        m_ref = nab;
        repeat (n_hold) @(posedge clk);
    endtask

    task automatic chk_all(input string tag, input int exp_mode, input int exp_err);
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("%s_mode%0d", tag, r), int'(mode_v[r]), exp_mode);
            chk($sformatf("%s_err%0d", tag, r), int'(err_v[r]), exp_err);
            chk($sformatf("%s_pending%0d", tag, r), sb_q[r].size(), 0);
        end
    endtask

    always @(negedge clk) begin
        for (int r = 0; r < 3; r++) begin
            while (sb_q[r].size() > 0 && sb_q[r][0].cyc < cyc) begin
                chk($sformatf("missed_en%0d", r), 0, 1);
                mon_e = sb_q[r].pop_front();
            end
            if (en_v[r]) begin
                if (sb_q[r].size() == 0) begin
                    chk($sformatf("spurious_en%0d", r), 1, 0);
                end else begin
                    mon_e = sb_q[r].pop_front();
                    chk($sformatf("en_cyc%0d", r), cyc, mon_e.cyc);
                    chk($sformatf("en_mode%0d", r), int'(mode_v[r]), mon_e.mode);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        a_in    = 1'b0;
        b_in    = 1'b0;
        err_clr = 1'b0;
        m_ref   = 2'b00;
        m_mode  = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("rst_en%0d", r), int'(en_v[r]), 0);
            chk($sformatf("rst_mode%0d", r), int'(mode_v[r]), 1);
            chk($sformatf("rst_err%0d", r), int'(err_v[r]), 0);
        end
        rst = 1'b0;
        repeat (12) @(posedge clk);

        // Forward: four full Gray cycles
        for (int k = 0; k < 4; k++) begin
            step_to(1'b1, 1'b0, 10);
            step_to(1'b1, 1'b1, 10);
            step_to(1'b0, 1'b1, 10);
            step_to(1'b0, 1'b0, 10);
        end
        chk_all("fwd", 1, 0);

        // One forward step, then two full reverse cycles
        step_to(1'b1, 1'b0, 10);
        step_to(1'b0, 1'b0, 10);
        chk_all("rev_first", 0, 0);
        step_to(1'b0, 1'b1, 10);
        step_to(1'b1, 1'b1, 10);
        step_to(1'b1, 1'b0, 10);
        step_to(1'b0, 1'b0, 10);
        step_to(1'b0, 1'b1, 10);
        step_to(1'b1, 1'b1, 10);
        step_to(1'b1, 1'b0, 10);
        chk_all("rev", 0, 0);

        // Short A glitch at AB=10 is filtered out
        @(posedge clk);
        #1 a_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_in = 1'b1;
        repeat (12) @(posedge clk);
        chk_all("glitch3", 0, 0);

        // A 6-cycle low pulse is real motion: one reverse then one forward step
        step_to(1'b0, 1'b0, 5);
        step_to(1'b1, 1'b0, 12);
        chk_all("glitch6", 1, 0);

        // Illegal 00 -> 11 step
        step_to(1'b0, 1'b0, 10);
        step_to(1'b1, 1'b1, 10);
        chk_all("illegal", 0, 1);
        step_to(1'b0, 1'b1, 10);
        chk_all("after_illegal", 1, 1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 3; r++)
            chk($sformatf("err_clr%0d", r), int'(err_v[r]), 0);

        // err_clr in the same cycle an illegal 01 -> 10 step is classified
        step_to(1'b1, 1'b0, FL + 2);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 3; r++)
            chk($sformatf("set_wins%0d", r), int'(err_v[r]), 1);
        repeat (8) @(posedge clk);
        chk_all("set_wins_hold", 1, 1);

        // Reverse into 11 with err still set, then a one-cycle reset
        step_to(1'b0, 1'b0, 10);
        step_to(1'b0, 1'b1, 10);
        step_to(1'b1, 1'b1, 10);
        chk_all("pre_rst", 0, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("midrst_en%0d", r), int'(en_v[r]), 0);
            chk($sformatf("midrst_mode%0d", r), int'(mode_v[r]), 1);
            chk($sformatf("midrst_err%0d", r), int'(err_v[r]), 0);
        end
        rst    = 1'b0;
        m_mode = 1;
        repeat (12) @(posedge clk);
        chk_all("post_rst", 1, 0);
        step_to(1'b0, 1'b1, 10);
        step_to(1'b0, 1'b0, 10);
        step_to(1'b1, 1'b0, 10);
        chk_all("resume", 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
